// File: rtl/chip_bus_slave_mem.sv
// rtl/chip_bus_slave_mem.sv - chip bus slave responder backed by a DEPTH x 64-bit register memory
// Optional build macro: PARITY_CHECK_EN (write-data even-parity check; rparity is always generated).
module chip_bus_slave_mem #(
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        request_i,
  input  logic        write_i,
  input  logic [63:0] address_i,
  input  logic [63:0] wdata_i,
  input  logic        wparity_i,
  output logic        grant_o,
  output logic        ready_o,
  output logic [63:0] rdata_o,
  output logic        rparity_o,
  output logic        error_o,
  output logic [7:0]  err_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_GNT  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_REL  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic        grant_q, grant_d;
  logic        ready_q, ready_d;
  logic [63:0] rdata_q, rdata_d;
  logic        rpar_q, rpar_d;
  logic        error_q, error_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic [63:0] mem_q [DEPTH];

  logic [AW-1:0] idx;
  logic          range_err;
  logic          parity_err;
  logic          err;
  logic          do_commit;

  assign idx       = addr_q[AW-1:0];
  assign range_err = |addr_q[63:AW];

`ifdef PARITY_CHECK_EN
  logic wpar_q, wpar_d;
  assign parity_err = wr_q & (wpar_q != ^wdata_q);
`else
  logic unused_wparity;
  assign unused_wparity = wparity_i;
  assign parity_err     = 1'b0;
`endif

  assign err       = range_err | parity_err;
  assign do_commit = (state_q == S_DONE) & wr_q & ~err;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
`ifdef PARITY_CHECK_EN
    wpar_d    = wpar_q;
`endif
    err_cnt_d = err_cnt_q;
    // Response outputs are single-cycle: they default low every cycle.
    grant_d   = 1'b0;
    ready_d   = 1'b0;
    rdata_d   = 64'd0;
    rpar_d    = 1'b0;
    error_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (request_i) begin
          wr_d    = write_i;
          addr_d  = address_i;
          wdata_d = wdata_i;
`ifdef PARITY_CHECK_EN
          wpar_d  = wparity_i;
`endif
          state_d = S_GNT;
        end
      end
      S_GNT: begin
        if (!request_i) begin
          state_d = S_IDLE;
        end else begin
          grant_d = 1'b1;
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_INIT != 4'd0) ? S_WAIT : S_DONE;
        end
      end
      S_WAIT: begin
        // A dropped request wins over reaching the end of the wait count.
        if (!request_i) begin
          state_d = S_IDLE;
        end else begin
          grant_d = 1'b1;
          cnt_d   = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = S_DONE;
        end
      end
      S_DONE: begin
        grant_d = 1'b1;
        ready_d = 1'b1;
        error_d = err;
        if (!wr_q && !range_err) rdata_d = mem_q[idx];
        rpar_d  = ^rdata_d;
        if (err && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        state_d = S_REL;
      end
      S_REL: begin
        if (!request_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      wr_q      <= 1'b0;
      addr_q    <= 64'd0;
      wdata_q   <= 64'd0;
`ifdef PARITY_CHECK_EN
      wpar_q    <= 1'b0;
`endif
      grant_q   <= 1'b0;
      ready_q   <= 1'b0;
      rdata_q   <= 64'd0;
      rpar_q    <= 1'b0;
      error_q   <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
`ifdef PARITY_CHECK_EN
      wpar_q    <= wpar_d;
`endif
      grant_q   <= grant_d;
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
      rpar_q    <= rpar_d;
      error_q   <= error_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock_i) begin
    if (do_commit) mem_q[idx] <= wdata_q;
  end

  assign grant_o     = grant_q;
  assign ready_o     = ready_q;
  assign rdata_o     = rdata_q;
  assign rparity_o   = rpar_q;
  assign error_o     = error_q;
  assign err_count_o = err_cnt_q;

endmodule

// File: tb/tb_chip_bus_slave_mem.sv
// tb/tb_chip_bus_slave_mem.sv - self-checking bench for chip_bus_slave_mem
module tb_chip_bus_slave_mem;

  localparam int DEPTH = 16;
  localparam int WAITC = 2;
`ifdef PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        request = 1'b0;
  logic        write = 1'b0;
  logic [63:0] address = 64'd0;
  logic [63:0] wdata = 64'd0;
  logic        wparity = 1'b0;
  logic        grant, ready, rparity, error;
  logic [63:0] rdata;
  logic [7:0]  err_count;

  chip_bus_slave_mem #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clock_i(clock), .reset_i(reset), .request_i(request), .write_i(write),
    .address_i(address), .wdata_i(wdata), .wparity_i(wparity),
    .grant_o(grant), .ready_o(ready), .rdata_o(rdata), .rparity_o(rparity),
    .error_o(error), .err_count_o(err_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        bad_par;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic        chk_rd;
    logic [63:0] rdata;
    logic        rpar;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   err_model = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic run_txn(input logic wr, input logic [63:0] addr, input logic [63:0] wd,
                         input logic wp, input exp_t e);
    int   n;
    bit   seen;
    exp_t got;
    sb_q.push_back(e);
    if (e.err && err_model < 255) err_model++;
    request = 1'b1; write = wr; address = addr; wdata = wd; wparity = wp;
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      tick();
      if (n == 0) chk("grant_after_edge0", {63'd0, grant}, 64'd0);
      if (n == 1) chk("grant_after_edge1", {63'd0, grant}, 64'd1);
      if (ready) seen = 1; else n++;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL ready_timeout actual=none required=ready");
      void'(sb_q.pop_front());
    end else begin
      chk("ready_latency", 64'(n), 64'(2 + WAITC));
      if (sb_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL scoreboard_empty actual=ready required=expectation");
      end else begin
        got = sb_q.pop_front();
        if (got.chk_rd) begin
          chk("rdata", rdata, got.rdata);
          chk("rparity", {63'd0, rparity}, {63'd0, got.rpar});
        end
        chk("error", {63'd0, error}, {63'd0, got.err});
        chk("err_count", {56'd0, err_count}, 64'(err_model));
      end
    end
    request = 1'b0;
    tick();
    chk("ready_cleared", {63'd0, ready}, 64'd0);
    chk("rdata_cleared", rdata, 64'd0);
    chk("error_cleared", {63'd0, error}, 64'd0);
  endtask

  function automatic vec_t mk(input logic wr, input logic [63:0] a, input logic [63:0] d,
                              input logic bp, input logic [63:0] er, input logic ee);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = d; v.bad_par = bp; v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  initial begin
    vec_t vecs[14];
    exp_t e;
    int   n;
    vecs[0]  = mk(1'b1, 64'd3,  64'hDEAD_BEEF_0000_0001, 1'b0, 64'd0, 1'b0);
    vecs[1]  = mk(1'b0, 64'd3,  64'd0, 1'b0, 64'hDEAD_BEEF_0000_0001, 1'b0);
    vecs[2]  = mk(1'b1, 64'd4,  64'd0, 1'b0, 64'd0, 1'b0);
    vecs[3]  = mk(1'b0, 64'd4,  64'd0, 1'b0, 64'd0, 1'b0);
    vecs[4]  = mk(1'b1, 64'd5,  64'h1234, 1'b0, 64'd0, 1'b0);
    vecs[5]  = mk(1'b1, 64'd5,  64'h1, 1'b1, 64'd0, PAR_EN);
    vecs[6]  = mk(1'b0, 64'd5,  64'd0, 1'b0, PAR_EN ? 64'h1234 : 64'h1, 1'b0);
    vecs[7]  = mk(1'b1, 64'd0,  64'hAAAA, 1'b0, 64'd0, 1'b0);
    vecs[8]  = mk(1'b1, 64'h10, 64'hFFFF, 1'b0, 64'd0, 1'b1);
    vecs[9]  = mk(1'b0, 64'd0,  64'd0, 1'b0, 64'hAAAA, 1'b0);
    vecs[10] = mk(1'b0, 64'h10, 64'd0, 1'b0, 64'd0, 1'b1);
    vecs[11] = mk(1'b0, 64'h8000_0000_0000_0003, 64'd0, 1'b0, 64'd0, 1'b1);
    vecs[12] = mk(1'b1, 64'd15, 64'hC0FF_EE00_1234_5677, 1'b0, 64'd0, 1'b0);
    vecs[13] = mk(1'b0, 64'd15, 64'd0, 1'b0, 64'hC0FF_EE00_1234_5677, 1'b0);

    tick(); tick();
    chk("rst_grant", {63'd0, grant}, 64'd0);
    chk("rst_ready", {63'd0, ready}, 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_rparity", {63'd0, rparity}, 64'd0);
    chk("rst_error", {63'd0, error}, 64'd0);
    chk("rst_err_count", {56'd0, err_count}, 64'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 14; i++) begin
      e.chk_rd = ~vecs[i].wr;
      e.rdata  = vecs[i].exp_rdata;
      e.rpar   = ^vecs[i].exp_rdata;
      e.err    = vecs[i].exp_err;
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, (^vecs[i].wdata) ^ vecs[i].bad_par, e);
    end

    // Drop request while in WAIT: a pending write to idx 3 must be abandoned.
    request = 1'b1; write = 1'b1; address = 64'd3; wdata = 64'h5555; wparity = ^wdata;
    tick(); tick(); tick();
    request = 1'b0;
    tick();
    chk("drop_grant", {63'd0, grant}, 64'd0);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (ready) n++;
      tick();
    end
    chk("drop_no_ready", 64'(n), 64'd0);
    chk("drop_err_count", {56'd0, err_count}, 64'(err_model));
    e.chk_rd = 1'b1; e.rdata = 64'hDEAD_BEEF_0000_0001; e.rpar = 1'b1; e.err = 1'b0;
    run_txn(1'b0, 64'd3, 64'd0, 1'b0, e);

    // Reset asserted mid-transaction clears outputs without waiting for a clock edge.
    request = 1'b1; write = 1'b0; address = 64'h20;
    tick(); tick(); tick();
    chk("pre_reset_grant", {63'd0, grant}, 64'd1);
    reset = 1'b1;
    #1;
    chk("midrst_grant", {63'd0, grant}, 64'd0);
    chk("midrst_ready", {63'd0, ready}, 64'd0);
    chk("midrst_rdata", rdata, 64'd0);
    chk("midrst_err_count", {56'd0, err_count}, 64'd0);
    err_model = 0;
    request = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // 256 errored completions: the count must stop at 255.
    e.chk_rd = 1'b1; e.rdata = 64'd0; e.rpar = 1'b0; e.err = 1'b1;
    for (int i = 0; i < 256; i++) run_txn(1'b0, 64'h40, 64'd0, 1'b0, e);
    chk("sat_err_count", {56'd0, err_count}, 64'd255);

    // Request held after ready: FSM parks in REL with no second grant.
    request = 1'b1; write = 1'b0; address = 64'd15;
    n = 0;
    while (!ready && n < 40) begin
      tick();
      n++;
    end
    chk("hold_ready_seen", {63'd0, ready}, 64'd1);
    chk("hold_rdata", rdata, 64'hC0FF_EE00_1234_5677);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (grant || ready) n++;
    end
    chk("hold_no_regrant", 64'(n), 64'd0);
    request = 1'b0;
    tick();
    chk("hold_err_count", {56'd0, err_count}, 64'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
